sniff_fifo_arb: RTL

- Arbitrates the capture/sniff FIFO (18-bit, first-word-fall-through) between two consumers: the register path (single-word reads) and the bulk streaming engine (burst reads).
- Sequences each access and returns an explicit empty indication.
- Terminates bursts on length, empty-timeout or abort.
- Sits between the FIFO and the register block / USB streaming logic, in the USB clock domain.

---
 rtl/sniff_fifo_arb.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/sniff_fifo_arb.sv
`default_nettype none
// ============================================================================
// sniff_fifo_arb : shares the FWFT capture FIFO between register reads and bursts
// Revision 1.0
// ============================================================================
module sniff_fifo_arb #(
  parameter int pDATA_WIDTH    = 18,
  parameter int pLEN_WIDTH     = 12,
  parameter int pTIMEOUT_WIDTH = 16
) (
  input  logic                      cwusb_clk,
  input  logic                      reset_i,
  input  logic [pDATA_WIDTH-1:0]    I_fifo_data,
  input  logic                      I_fifo_empty,
  output logic                      O_fifo_read,
  input  logic                      reg_req_i,
  output logic                      reg_ack_o,
  output logic [pDATA_WIDTH-1:0]    reg_data_o,
  output logic                      reg_empty_o,
  input  logic                      strm_req_i,
  input  logic [pLEN_WIDTH-1:0]     strm_len_i,
  input  logic                      strm_abort_i,
  input  logic                      strm_ready_i,
  output logic                      strm_valid_o,
  output logic [pDATA_WIDTH-1:0]    strm_data_o,
  output logic                      strm_busy_o,
  output logic                      strm_done_o,
  output logic                      strm_timeout_o,
  output logic [pLEN_WIDTH-1:0]     strm_count_o,
  input  logic [pTIMEOUT_WIDTH-1:0] cfg_timeout_i
);

  localparam logic [pLEN_WIDTH-1:0]     c_LEN_ONE = {{(pLEN_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [pTIMEOUT_WIDTH-1:0] c_TMO_ONE = {{(pTIMEOUT_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REG   = 2'd1,
    S_BURST = 2'd2,
    S_SDONE = 2'd3
  } state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic                      r_last_strm;
  logic [pLEN_WIDTH-1:0]     r_remaining;
  logic [pLEN_WIDTH-1:0]     r_count;
  logic [pTIMEOUT_WIDTH-1:0] r_empty_cnt;
  logic [pTIMEOUT_WIDTH-1:0] w_empty_inc;
  logic                      r_tmo_flag;
  logic                      r_reg_ack;
  logic [pDATA_WIDTH-1:0]    r_reg_data;
  logic                      r_reg_empty;
  logic                      w_grant_reg;
  logic                      w_grant_strm;
  logic                      w_valid;
  logic                      w_pop;
  logic                      w_tmo_hit;

  always_comb begin
    w_state_nxt  = r_state;
    w_grant_reg  = 1'b0;
    w_grant_strm = 1'b0;
    w_valid      = 1'b0;
    w_pop        = 1'b0;
    w_tmo_hit    = 1'b0;
    w_empty_inc  = (r_empty_cnt == '1) ? r_empty_cnt : (r_empty_cnt + c_TMO_ONE);
    case (r_state)
      S_IDLE: begin
        // On a tie the requester that did not win last time is served
        if (reg_req_i && strm_req_i) begin
          w_grant_reg  = r_last_strm;
          w_grant_strm = ~r_last_strm;
        end else begin
          w_grant_reg  = reg_req_i;
          w_grant_strm = strm_req_i;
        end
        if (w_grant_reg) begin
          w_state_nxt = S_REG;
        end else if (w_grant_strm) begin
          w_state_nxt = (strm_len_i == '0) ? S_SDONE : S_BURST;
        end
      end
      S_REG: begin
        w_pop       = ~I_fifo_empty;
        w_state_nxt = S_IDLE;
      end
      S_BURST: begin
        w_valid   = ~I_fifo_empty;
        w_pop     = w_valid & strm_ready_i & ~strm_abort_i;
        w_tmo_hit = I_fifo_empty && (cfg_timeout_i != '0) && (w_empty_inc >= cfg_timeout_i);
        if (strm_abort_i) begin
          w_state_nxt = S_SDONE;
        end else if (w_pop && (r_remaining == c_LEN_ONE)) begin
          w_state_nxt = S_SDONE;
        end else if (w_tmo_hit) begin
          w_state_nxt = S_SDONE;
        end
      end
      S_SDONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    if (reset_i) begin
      w_pop   = 1'b0;
      w_valid = 1'b0;
    end
  end

  always_ff @(posedge cwusb_clk) begin
    if (reset_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge cwusb_clk) begin
    if (reset_i) begin
      r_last_strm <= 1'b1;
      r_remaining <= '0;
      r_count     <= '0;
      r_empty_cnt <= '0;
      r_tmo_flag  <= 1'b0;
      r_reg_ack   <= 1'b0;
      r_reg_data  <= '0;
      r_reg_empty <= 1'b0;
    end else begin
      r_reg_ack <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_grant_reg) begin
            r_last_strm <= 1'b0;
          end else if (w_grant_strm) begin
            r_last_strm <= 1'b1;
            r_remaining <= strm_len_i;
            r_count     <= '0;
            r_empty_cnt <= '0;
            r_tmo_flag  <= 1'b0;
          end
        end
        S_REG: begin
          r_reg_ack   <= 1'b1;
          r_reg_data  <= I_fifo_empty ? '0 : I_fifo_data;
          r_reg_empty <= I_fifo_empty;
        end
        S_BURST: begin
          if (strm_abort_i) begin
            r_tmo_flag <= 1'b0;
          end else if (w_pop) begin
            r_remaining <= r_remaining - c_LEN_ONE;
            r_count     <= r_count + c_LEN_ONE;
            r_empty_cnt <= '0;
          end else if (I_fifo_empty) begin
            r_empty_cnt <= w_empty_inc;
            if (w_tmo_hit) begin
              r_tmo_flag <= 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign O_fifo_read    = w_pop;
  assign reg_ack_o      = r_reg_ack;
  assign reg_data_o     = r_reg_data;
  assign reg_empty_o    = r_reg_empty;
  assign strm_valid_o   = w_valid;
  assign strm_data_o    = I_fifo_data;
  assign strm_busy_o    = (r_state == S_BURST) || (r_state == S_SDONE);
  assign strm_done_o    = (r_state == S_SDONE);
  assign strm_timeout_o = (r_state == S_SDONE) && r_tmo_flag;
  assign strm_count_o   = r_count;

endmodule
`default_nettype wire
